// File: rtl/cl_sertc_uart_tx.sv
// Camera Link SerTC UART transmitter: byte FIFO feeding an 8N1 serialiser.
// The serial line leaves through a flop so the LVDS buffer never sees a glitch.
module cl_sertc_uart_tx #(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned BAUD        = 9600,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          ser_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    if (DIV < 2) begin : g_div_chk
        $error("cl_sertc_uart_tx: bit period DIV must be at least 2 clock cycles");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("cl_sertc_uart_tx: FIFO_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_ser_tx;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic [7:0]      r_mem [FIFO_DEPTH];

    logic            w_push;
    logic            w_pop;
    logic            w_bit_end;
    logic            w_not_empty;
    logic            w_ser_nxt;

    assign w_not_empty = (r_level != '0);
    assign s_ready     = (r_level != LVL_FULL);
    assign w_push      = s_valid && s_ready;
    assign w_bit_end   = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_ser_nxt   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_not_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_ser_nxt = 1'b0;
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_ser_nxt = r_shift[0];
                if (w_bit_end && (r_idx == 3'd7)) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                // Pop straight into the next start bit so back-to-back frames have no gap.
                if (w_bit_end) begin
                    if (w_not_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_ser_tx <= 1'b1;
        end else begin
            if ((w_state_nxt != r_state) || w_bit_end) r_cnt <= '0;
            else                                       r_cnt <= r_cnt + CNT_ONE;

            if (r_state == S_START)                   r_idx <= '0;
            else if ((r_state == S_DATA) && w_bit_end) r_idx <= r_idx + 3'd1;

            if (w_pop)                                 r_shift <= r_mem[r_rd_ptr];
            else if ((r_state == S_DATA) && w_bit_end) r_shift <= {1'b0, r_shift[7:1]};

            r_ser_tx <= w_ser_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: the level counter alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_data;
    end

    assign ser_tx     = r_ser_tx;
    assign fifo_level = r_level;
    assign busy       = (r_state != S_IDLE) || w_not_empty;

endmodule
